// File: rtl/enemy_fire_pkg.sv
// Shared constants and types for the enemy bullet scheduler.
// Coordinates are 10-bit screen pixels; y wraps the visible band 480..959.
package enemy_fire_pkg;

    localparam int COORD_W  = 10;
    localparam int SPAWN_DX = 23;
    localparam int SPAWN_DY = 40;
    localparam int Y_LIMIT  = 960;
    localparam int PLANE_W  = 2;
    localparam int SLOT_W   = 2;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   ycalc_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with one-hot grant.
// The search starts at ptr; ptr moves past the winner only on accept.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && found) begin
            ptr <= PW'((int'(win) + 1) % N);
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Enemy bullet pool: per-plane cooldowns, round-robin fire arbitration,
// lowest-free-slot allocation, bullet movement and retirement.
module enemy_fire_scheduler
    import enemy_fire_pkg::*;
#(
    parameter int N_PLANES    = 4,
    parameter int N_SLOTS     = 4,
    parameter int FIRE_PERIOD = 480,
    parameter int SPEED       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [N_PLANES-1:0]          plane_exist,
    input  logic [COORD_W*N_PLANES-1:0]  plane_x,
    input  logic [COORD_W*N_PLANES-1:0]  plane_y,
    input  logic [N_SLOTS-1:0]           slot_hit,
    output logic [N_SLOTS-1:0]           slot_valid,
    output logic [COORD_W*N_SLOTS-1:0]   slot_x,
    output logic [COORD_W*N_SLOTS-1:0]   slot_y,
    output logic [PLANE_W*N_SLOTS-1:0]   slot_owner,
    output logic                         fire_grant,
    output logic [PLANE_W-1:0]           grant_plane,
    output logic                         pool_full
);

    localparam int CD_W = $clog2(FIRE_PERIOD + 1);
    localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(FIRE_PERIOD);
    localparam ycalc_t Y_STEP = ycalc_t'(SPEED);
    localparam ycalc_t Y_LIM  = ycalc_t'(Y_LIMIT);

    logic [CD_W-1:0]     cooldown [N_PLANES];
    logic [N_PLANES-1:0] pending;
    logic [N_PLANES-1:0] req;
    logic [N_PLANES-1:0] plane_gnt;
    logic [PLANE_W-1:0]  gnt_idx;
    logic [SLOT_W-1:0]   free_idx;
    logic                any_free;
    logic                do_grant;
    coord_t              spawn_x;
    coord_t              spawn_y;
    ycalc_t              ny;

    logic [N_SLOTS-1:0]         valid_n;
    logic [COORD_W*N_SLOTS-1:0] x_n;
    logic [COORD_W*N_SLOTS-1:0] y_n;
    logic [PLANE_W*N_SLOTS-1:0] owner_n;

    // A plane that disappears while pending must not win this cycle.
    assign req      = pending & plane_exist;
    assign do_grant = any_free && (|req);

    rr_arbiter #(
        .N(N_PLANES)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (do_grant),
        .gnt    (plane_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_PLANES; i++) begin
            if (plane_gnt[i]) gnt_idx = PLANE_W'(i);
        end
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int j = N_SLOTS - 1; j >= 0; j--) begin
            if (!slot_valid[j]) begin
                any_free = 1'b1;
                free_idx = SLOT_W'(j);
            end
        end
    end

    assign spawn_x = plane_x[COORD_W*gnt_idx +: COORD_W] + coord_t'(SPAWN_DX);
    assign spawn_y = plane_y[COORD_W*gnt_idx +: COORD_W] + coord_t'(SPAWN_DY);

    // Hit beats off-screen beats movement; a fresh slot never moves.
    always_comb begin
        valid_n = slot_valid;
        x_n     = slot_x;
        y_n     = slot_y;
        owner_n = slot_owner;
        ny      = '0;
        for (int j = 0; j < N_SLOTS; j++) begin
            ny = {1'b0, slot_y[COORD_W*j +: COORD_W]} + Y_STEP;
            if (do_grant && free_idx == SLOT_W'(j)) begin
                valid_n[j]                   = 1'b1;
                x_n[COORD_W*j +: COORD_W]    = spawn_x;
                y_n[COORD_W*j +: COORD_W]    = spawn_y;
                owner_n[PLANE_W*j +: PLANE_W] = gnt_idx;
            end else if (slot_valid[j]) begin
                if (slot_hit[j]) begin
                    valid_n[j] = 1'b0;
                end else if (tick) begin
                    if (ny >= Y_LIM) begin
                        valid_n[j] = 1'b0;
                    end else begin
                        y_n[COORD_W*j +: COORD_W] = ny[COORD_W-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PLANES; i++) begin
                cooldown[i] <= CD_RELOAD;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < N_PLANES; i++) begin
                if (!plane_exist[i]) begin
                    cooldown[i] <= CD_RELOAD;
                    pending[i]  <= 1'b0;
                end else if (do_grant && plane_gnt[i]) begin
                    cooldown[i] <= CD_RELOAD;
                    pending[i]  <= 1'b0;
                end else begin
                    if (tick && cooldown[i] != '0) begin
                        cooldown[i] <= cooldown[i] - 1'b1;
                    end
                    if (cooldown[i] == '0) begin
                        pending[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid  <= '0;
            slot_x      <= '0;
            slot_y      <= '0;
            slot_owner  <= '0;
            fire_grant  <= 1'b0;
            grant_plane <= '0;
            pool_full   <= 1'b0;
        end else begin
            slot_valid <= valid_n;
            slot_x     <= x_n;
            slot_y     <= y_n;
            slot_owner <= owner_n;
            fire_grant <= do_grant;
            pool_full  <= &valid_n;
            if (do_grant) begin
                grant_plane <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed bench for enemy_fire_scheduler with a grant scoreboard.
module tb_enemy_fire_scheduler;
    import enemy_fire_pkg::*;

    localparam int NP = 4;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [NP-1:0] plane_exist;
    logic [39:0]   plane_x;
    logic [39:0]   plane_y;
    logic [NS-1:0] slot_hit;
    logic [NS-1:0] slot_valid;
    logic [39:0]   slot_x;
    logic [39:0]   slot_y;
    logic [7:0]    slot_owner;
    logic          fire_grant;
    logic [1:0]    grant_plane;
    logic          pool_full;

    enemy_fire_scheduler #(
        .N_PLANES(NP), .N_SLOTS(NS), .FIRE_PERIOD(4), .SPEED(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .plane_exist(plane_exist), .plane_x(plane_x), .plane_y(plane_y),
        .slot_hit(slot_hit), .slot_valid(slot_valid),
        .slot_x(slot_x), .slot_y(slot_y), .slot_owner(slot_owner),
        .fire_grant(fire_grant), .grant_plane(grant_plane),
        .pool_full(pool_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] plane;
        int         slot;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input int s);
        exp_t e;
        e.plane = p[1:0];
        e.slot  = s;
        e.x     = plane_x[10*p +: 10] + 10'd23;
        e.y     = plane_y[10*p +: 10] + 10'd40;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && fire_grant) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("grant_plane", grant_plane, mon_e.plane);
                chk("grant_valid", slot_valid[mon_e.slot], 1);
                chk("grant_owner", slot_owner[2*mon_e.slot +: 2], mon_e.plane);
                chk("grant_x", slot_x[10*mon_e.slot +: 10], mon_e.x);
                chk("grant_y", slot_y[10*mon_e.slot +: 10], mon_e.y);
            end
        end
    end

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        plane_exist = '0;
        slot_hit = '0;
        plane_x = '0;
        plane_y = '0;
        step(2);
        chk("rst_valid", slot_valid, 0);
        chk("rst_x", slot_x, 0);
        chk("rst_y", slot_y, 0);
        chk("rst_owner", slot_owner, 0);
        chk("rst_grant", fire_grant, 0);
        chk("rst_gplane", grant_plane, 0);
        chk("rst_full", pool_full, 0);
        rst = 1'b0;

        // single plane, cooldown 4, tick every clk
        plane_x[9:0] = 10'd100;
        plane_y[9:0] = 10'd50;
        plane_exist = 4'b0001;
        tick = 1'b1;
        push(0, 0);
        push(0, 1);
        step(5);
        chk("s1_no_early", fire_grant, 0);
        step(1);
        chk("s1_first", fire_grant, 1);
        step(5);
        chk("s1_gap", fire_grant, 0);
        step(1);
        chk("s1_period", fire_grant, 1);
        chk("s1_move", slot_y[9:0], 96);

        // plane dies while pending
        step(5);
        plane_exist = 4'b0000;
        step(1);
        chk("s6_no_grant", fire_grant, 0);
        step(3);
        chk("s6_valid", slot_valid, 4'b0011);
        chk("s6_y0", slot_y[9:0], 105);
        chk("s6_y1", slot_y[19:10], 99);

        // async reset with bullets in flight
        rst = 1'b1;
        #1;
        chk("arst_valid", slot_valid, 0);
        chk("arst_y", slot_y, 0);
        tick = 1'b0;
        step(1);
        rst = 1'b0;

        // all four planes pending together
        for (int i = 0; i < NP; i++) begin
            plane_x[10*i +: 10] = 10'(100 + 50 * i);
            plane_y[10*i +: 10] = 10'(10 + 20 * i);
            push(i, i);
        end
        plane_exist = 4'b1111;
        tick = 1'b1;
        step(4);
        tick = 1'b0;
        step(1);
        chk("s2_pend_only", fire_grant, 0);
        step(1);
        chk("s2_g0", fire_grant, 1);
        step(2);
        chk("s2_not_full", pool_full, 0);
        step(1);
        chk("s2_full", pool_full, 1);
        chk("s2_valid", slot_valid, 4'b1111);

        // pool full, plane 2 pending, slot 1 hit
        push(2, 1);
        plane_exist = 4'b0100;
        tick = 1'b1;
        step(4);
        tick = 1'b0;
        step(3);
        chk("s3_held", fire_grant, 0);
        chk("s3_full", pool_full, 1);
        slot_hit = 4'b0010;
        step(1);
        slot_hit = 4'b0000;
        chk("s3_freed", slot_valid, 4'b1101);
        chk("s3_wait", fire_grant, 0);
        step(1);
        chk("s3_regrant", fire_grant, 1);
        chk("s3_refull", pool_full, 1);

        // hit and tick in the same clk
        tick = 1'b1;
        slot_hit = 4'b1000;
        step(1);
        tick = 1'b0;
        slot_hit = 4'b0000;
        chk("s5_valid", slot_valid, 4'b0111);
        chk("s5_y3", slot_y[39:30], 114);
        chk("s5_y0", slot_y[9:0], 55);

        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // bullet at the bottom edge
        plane_x = '0;
        plane_y = '0;
        plane_y[9:0] = 10'd919;
        plane_exist = 4'b0001;
        push(0, 0);
        tick = 1'b1;
        step(4);
        tick = 1'b0;
        step(2);
        chk("s4_grant", fire_grant, 1);
        step(1);
        chk("s4_alive", slot_valid[0], 1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        chk("s4_gone", slot_valid[0], 0);
        chk("s4_y", slot_y[9:0], 959);
        chk("s4_full", pool_full, 0);

        step(2);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
# enemy_fire_scheduler

Shares a fixed pool of enemy-bullet slots among several enemy planes. Per-plane fire cooldowns, a round-robin fire arbiter and slot allocation/retirement sit in one block. It sits between the enemy-plane movers and the VGA bullet renderer / collision checker, and owns every enemy-bullet position and lifetime.

## Interface
Parameters:
- N_PLANES, 4: number of enemy planes (requesters)
- N_SLOTS, 4: number of bullet slots in the pool
- FIRE_PERIOD, 480: ticks between shots of one plane
- SPEED, 1: y pixels added per tick

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-clk movement strobe, already synchronous to clk
- plane_exist  in  N_PLANES  1 = plane alive
- plane_x  in  10*N_PLANES  plane i x at bits [10i+9:10i]
- plane_y  in  10*N_PLANES  plane i y, same packing
- slot_hit  in  N_SLOTS  one-clk pulse: slot j bullet collided
- slot_valid  out  N_SLOTS  1 = slot j bullet in flight
- slot_x  out  10*N_SLOTS  bullet x, packed
- slot_y  out  10*N_SLOTS  bullet y, packed, 0..1023 with visible band 480..959
- slot_owner  out  2*N_SLOTS  index of the plane that fired slot j
- fire_grant  out  1  one-clk pulse: a shot was allocated this cycle
- grant_plane  out  2  plane index of the last grant
- pool_full  out  1  all slots valid

## Operation
- Reset: slot_valid=0, slot_x=slot_y=0, slot_owner=0, fire_grant=0, grant_plane=0, pool_full=0, every cooldown=FIRE_PERIOD, every pending=0, round-robin pointer=0.
- Cooldown, per plane:
  - On tick, with plane_exist=1 and cooldown>0: decrement.
  - When cooldown is 0 and plane_exist=1: set pending.
  - plane_exist=0: cooldown is forced to FIRE_PERIOD and pending is cleared. Bullets already in flight continue.
- Arbiter, each clk: if any pending and a free slot exists, grant exactly one plane.
  - Plane choice is round-robin, starting at pointer.
  - Slot choice is the lowest-index free slot.
  - Pointer then moves to granted+1, mod N_PLANES.
- Grant actions, all registered in one edge:
  - slot_x = plane_x+23, slot_y = plane_y+40, both truncated to 10 bits.
  - slot_valid=1, slot_owner=plane.
  - That plane's pending clears and its cooldown reloads to FIRE_PERIOD.
  - fire_grant=1, grant_plane=plane.
- No free slot: pending is held, not dropped, and is granted when a slot frees.
- Movement: on tick, each valid slot gets y += SPEED. If the new y is 960 or more, the slot is invalidated.
- Retire priority, highest first: slot_hit, then off-screen, then movement.
  - A slot with slot_hit=1 clears valid that cycle, even if tick is also high.
- A freed slot is allocatable only from the next clk. The free vector is the registered slot_valid.
- A newly granted slot does not move on the grant cycle even if tick=1.
- slot_hit on an invalid slot: ignored.
- pool_full is the AND of the registered slot_valid.

## Timing
- Pending is registered on the clk after cooldown reaches 0.
- Grant appears on the next clk, so the shot is visible 2 clks after the zero-reaching tick.
- Throughput: at most one grant per clk.
- slot_hit to slot_valid=0: 1 clk. The slot is reusable by a grant 1 clk later.
- All outputs come directly from flops; no combinational input-to-output path.
- rst is asynchronous mid-flight: all slots drop immediately.

## Structure
- Shared package enemy_fire_pkg holds:
  - COORD_W=10, SPAWN_DX=23, SPAWN_DY=40, Y_LIMIT=960
  - the plane and slot index widths
- Sub-module rr_arbiter (N-way round-robin, one-hot grant, pointer update on accept), parameterised on N.
- Lowest-free-slot select and the slot datapath stay inline.

## Test plan
- Plane 0 exists at (100,50), FIRE_PERIOD=4, tick every clk:
  - fire_grant fires 2 clks after the 4th tick, then every 6 clks.
  - First grant is slot 0 at (123,90).
- All 4 planes pending in the same cycle, pointer=0:
  - Grants go to planes 0,1,2,3 on consecutive clks, into slots 0,1,2,3.
  - pool_full=1 after the 4th grant.
- Pool full with plane 2 pending; slot_hit[1] pulses:
  - slot_valid[1]=0 next clk.
  - Plane 2 is granted into slot 1 the clk after that.
- Slot at y=959, tick with SPEED=1 -> slot_valid clears; no y=960 value is ever visible.
- slot_hit and tick in the same clk on a valid slot -> slot invalidated and y unchanged.
- Plane deasserts plane_exist while pending -> no grant, and its in-flight bullet keeps moving until retired.
